// File: rtl/ex_mem_stage_buffer.sv
// Execute-to-memory pipeline stage with a 2-entry skid buffer.
// The main entry drives the memory stage. The skid entry catches one
// instruction that is accepted while the memory stage is stalling.
// in_ready is registered, so back-pressure never forms a combinational
// path from out_ready to in_ready.
module ex_mem_stage_buffer #(
  parameter int SCALAR_W   = 16,
  parameter int VECTOR_W   = 128,
  parameter int REG_ADDR_W = 5,
  parameter int WB_SEL_W   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,

  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  wre_in,
  input  logic                  vector_wre_in,
  input  logic                  mem_we_a_in,
  input  logic                  mem_we_b_in,
  input  logic [WB_SEL_W-1:0]   wb_sel_in,
  input  logic [WB_SEL_W-1:0]   vwb_sel_in,
  input  logic [REG_ADDR_W-1:0] rs1_in,
  input  logic [REG_ADDR_W-1:0] rs2_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [SCALAR_W-1:0]   alu_result_in,
  input  logic [SCALAR_W-1:0]   srcA_in,
  input  logic [SCALAR_W-1:0]   srcB_in,
  input  logic [VECTOR_W-1:0]   valu_result_in,
  input  logic [VECTOR_W-1:0]   vsrcB_in,

  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  wre_out,
  output logic                  vector_wre_out,
  output logic                  mem_we_a_out,
  output logic                  mem_we_b_out,
  output logic [WB_SEL_W-1:0]   wb_sel_out,
  output logic [WB_SEL_W-1:0]   vwb_sel_out,
  output logic [REG_ADDR_W-1:0] rs1_out,
  output logic [REG_ADDR_W-1:0] rs2_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [SCALAR_W-1:0]   alu_result_out,
  output logic [SCALAR_W-1:0]   srcA_out,
  output logic [SCALAR_W-1:0]   srcB_out,
  output logic [VECTOR_W-1:0]   valu_result_out,
  output logic [VECTOR_W-1:0]   vsrcB_out,

  output logic [1:0]            occupancy
);

  localparam int PAY_W = 4 + 2*WB_SEL_W + 3*REG_ADDR_W + 3*SCALAR_W + 2*VECTOR_W;

  logic [PAY_W-1:0] pay_in;
  logic [PAY_W-1:0] main_pay_p1;
  logic [PAY_W-1:0] skid_pay_p1;
  logic             main_vld_p1;
  logic             skid_vld_p1;
  logic             in_ready_q;
  logic [1:0]       occ_q;

  logic             accept;
  logic             pop;
  logic             main_vld_nx;
  logic             skid_vld_nx;
  logic             load_main_from_in;
  logic             load_main_from_skid;
  logic             load_skid;

  logic             main_wre;
  logic             main_vwre;
  logic             main_we_a;
  logic             main_we_b;

  assign pay_in = {wre_in, vector_wre_in, mem_we_a_in, mem_we_b_in,
                   wb_sel_in, vwb_sel_in, rs1_in, rs2_in, rd_in,
                   alu_result_in, srcA_in, srcB_in, valu_result_in, vsrcB_in};

  assign accept = in_valid & in_ready_q;
  assign pop    = main_vld_p1 & out_ready;

  // Next-state of the two entries: refill main from skid first (FIFO order), else from input.
  always_comb begin
    main_vld_nx         = main_vld_p1;
    skid_vld_nx         = skid_vld_p1;
    load_main_from_in   = 1'b0;
    load_main_from_skid = 1'b0;
    load_skid           = 1'b0;
    if (flush) begin
      main_vld_nx = 1'b0;
      skid_vld_nx = 1'b0;
    end else if (!main_vld_p1 || pop) begin
      if (skid_vld_p1) begin
        load_main_from_skid = 1'b1;
        main_vld_nx         = 1'b1;
        skid_vld_nx         = 1'b0;
      end else if (accept) begin
        load_main_from_in = 1'b1;
        main_vld_nx       = 1'b1;
      end else begin
        main_vld_nx = 1'b0;
      end
    end else if (accept) begin
      load_skid   = 1'b1;
      skid_vld_nx = 1'b1;
    end
  end

  // Stage registers: valid bits, registered ready/occupancy, and the two payload slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld_p1 <= 1'b0;
      skid_vld_p1 <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
      main_pay_p1 <= '0;
      skid_pay_p1 <= '0;
    end else begin
      main_vld_p1 <= main_vld_nx;
      skid_vld_p1 <= skid_vld_nx;
      in_ready_q  <= !skid_vld_nx;
      occ_q       <= {1'b0, main_vld_nx} + {1'b0, skid_vld_nx};
      if (load_main_from_skid) begin
        main_pay_p1 <= skid_pay_p1;
      end else if (load_main_from_in) begin
        main_pay_p1 <= pay_in;
      end
      if (load_skid) begin
        skid_pay_p1 <= pay_in;
      end
    end
  end

  // ---- memory-stage side: main entry unpacked onto the outputs ----
  assign {main_wre, main_vwre, main_we_a, main_we_b,
          wb_sel_out, vwb_sel_out, rs1_out, rs2_out, rd_out,
          alu_result_out, srcA_out, srcB_out, valu_result_out, vsrcB_out} = main_pay_p1;

  // Enables are gated so a bubble or killed entry can never write state.
  assign wre_out        = main_wre  & main_vld_p1;
  assign vector_wre_out = main_vwre & main_vld_p1;
  assign mem_we_a_out   = main_we_a & main_vld_p1;
  assign mem_we_b_out   = main_we_b & main_vld_p1;

  assign out_valid = main_vld_p1;
  assign in_ready  = in_ready_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_ex_mem_stage_buffer.sv
// Bench for ex_mem_stage_buffer: a default-width and a wide instance share
// one control stream and are checked against a 2-deep FIFO reference.
module tb_ex_mem_stage_buffer;

  typedef struct packed {
    logic         wre;
    logic         vwre;
    logic         mwa;
    logic         mwb;
    logic [1:0]   wb_sel;
    logic [1:0]   vwb_sel;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic [31:0]  alu;
    logic [31:0]  srcA;
    logic [31:0]  srcB;
    logic [255:0] valu;
    logic [255:0] vsrcB;
  } pay_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  pay_t cur_in = '0;

  int n_checks = 0;
  int n_fail = 0;
  bit started = 1'b0;

  // reference state: the held entries in order, plus the last head seen
  pay_t q[$];
  pay_t last_head = '0;

  // narrow instance outputs
  logic         n_in_ready, n_out_valid;
  logic         n_wre, n_vwre, n_mwa, n_mwb;
  logic [1:0]   n_wb_sel, n_vwb_sel, n_occ;
  logic [4:0]   n_rs1, n_rs2, n_rd;
  logic [15:0]  n_alu, n_srcA, n_srcB;
  logic [127:0] n_valu, n_vsrcB;

  // wide instance outputs
  logic         w_in_ready, w_out_valid;
  logic         w_wre, w_vwre, w_mwa, w_mwb;
  logic [1:0]   w_wb_sel, w_vwb_sel, w_occ;
  logic [4:0]   w_rs1, w_rs2, w_rd;
  logic [31:0]  w_alu, w_srcA, w_srcB;
  logic [255:0] w_valu, w_vsrcB;

  always #5 clk = ~clk;

  ex_mem_stage_buffer #(.SCALAR_W(16), .VECTOR_W(128), .REG_ADDR_W(5), .WB_SEL_W(2)) dut_n (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready),
    .wre_in(cur_in.wre), .vector_wre_in(cur_in.vwre),
    .mem_we_a_in(cur_in.mwa), .mem_we_b_in(cur_in.mwb),
    .wb_sel_in(cur_in.wb_sel), .vwb_sel_in(cur_in.vwb_sel),
    .rs1_in(cur_in.rs1), .rs2_in(cur_in.rs2), .rd_in(cur_in.rd),
    .alu_result_in(cur_in.alu[15:0]), .srcA_in(cur_in.srcA[15:0]), .srcB_in(cur_in.srcB[15:0]),
    .valu_result_in(cur_in.valu[127:0]), .vsrcB_in(cur_in.vsrcB[127:0]),
    .out_valid(n_out_valid), .out_ready(out_ready),
    .wre_out(n_wre), .vector_wre_out(n_vwre), .mem_we_a_out(n_mwa), .mem_we_b_out(n_mwb),
    .wb_sel_out(n_wb_sel), .vwb_sel_out(n_vwb_sel),
    .rs1_out(n_rs1), .rs2_out(n_rs2), .rd_out(n_rd),
    .alu_result_out(n_alu), .srcA_out(n_srcA), .srcB_out(n_srcB),
    .valu_result_out(n_valu), .vsrcB_out(n_vsrcB),
    .occupancy(n_occ)
  );

  ex_mem_stage_buffer #(.SCALAR_W(32), .VECTOR_W(256), .REG_ADDR_W(5), .WB_SEL_W(2)) dut_w (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(w_in_ready),
    .wre_in(cur_in.wre), .vector_wre_in(cur_in.vwre),
    .mem_we_a_in(cur_in.mwa), .mem_we_b_in(cur_in.mwb),
    .wb_sel_in(cur_in.wb_sel), .vwb_sel_in(cur_in.vwb_sel),
    .rs1_in(cur_in.rs1), .rs2_in(cur_in.rs2), .rd_in(cur_in.rd),
    .alu_result_in(cur_in.alu), .srcA_in(cur_in.srcA), .srcB_in(cur_in.srcB),
    .valu_result_in(cur_in.valu), .vsrcB_in(cur_in.vsrcB),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .wre_out(w_wre), .vector_wre_out(w_vwre), .mem_we_a_out(w_mwa), .mem_we_b_out(w_mwb),
    .wb_sel_out(w_wb_sel), .vwb_sel_out(w_vwb_sel),
    .rs1_out(w_rs1), .rs2_out(w_rs2), .rd_out(w_rd),
    .alu_result_out(w_alu), .srcA_out(w_srcA), .srcB_out(w_srcB),
    .valu_result_out(w_valu), .vsrcB_out(w_vsrcB),
    .occupancy(w_occ)
  );

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic pay_t rand_pay();
    pay_t p;
    p.wre     = 1'($urandom);
    p.vwre    = 1'($urandom);
    p.mwa     = 1'($urandom);
    p.mwb     = 1'($urandom);
    p.wb_sel  = 2'($urandom);
    p.vwb_sel = 2'($urandom);
    p.rs1     = 5'($urandom);
    p.rs2     = 5'($urandom);
    p.rd      = 5'($urandom);
    p.alu     = $urandom;
    p.srcA    = $urandom;
    p.srcB    = $urandom;
    for (int i = 0; i < 8; i++) begin
      p.valu[i*32 +: 32]  = $urandom;
      p.vsrcB[i*32 +: 32] = $urandom;
    end
    return p;
  endfunction

  function automatic logic [639:0] n_pay_act();
    return 640'({n_wre, n_vwre, n_mwa, n_mwb, n_wb_sel, n_vwb_sel, n_rs1, n_rs2, n_rd,
                 n_alu, n_srcA, n_srcB, n_valu, n_vsrcB});
  endfunction

  function automatic logic [639:0] w_pay_act();
    return 640'({w_wre, w_vwre, w_mwa, w_mwb, w_wb_sel, w_vwb_sel, w_rs1, w_rs2, w_rd,
                 w_alu, w_srcA, w_srcB, w_valu, w_vsrcB});
  endfunction

  // Reference: a FIFO of at most two entries; accept only when not full.
  always @(posedge clk) begin
    int  sz;
    bit  acc;
    bit  pp;
    sz  = q.size();
    acc = in_valid && (sz < 2);
    pp  = (sz > 0) && out_ready;
    if (reset) begin
      q.delete();
      last_head = '0;
      started   = 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(cur_in);
    end
    if (q.size() > 0) last_head = q[0];
  end

  // Compare both instances against the reference every cycle.
  always @(negedge clk) begin
    pay_t h;
    bit   v;
    int   sz;
    if (started) begin
      sz = q.size();
      v  = (sz > 0);
      h  = v ? q[0] : last_head;
      chk("n_ctrl", 640'({n_out_valid, n_in_ready, n_occ}), 640'({v, (sz < 2), 2'(sz)}));
      chk("w_ctrl", 640'({w_out_valid, w_in_ready, w_occ}), 640'({v, (sz < 2), 2'(sz)}));
      chk("n_payload", n_pay_act(),
          640'({h.wre & v, h.vwre & v, h.mwa & v, h.mwb & v, h.wb_sel, h.vwb_sel,
                h.rs1, h.rs2, h.rd, h.alu[15:0], h.srcA[15:0], h.srcB[15:0],
                h.valu[127:0], h.vsrcB[127:0]}));
      chk("w_payload", w_pay_act(),
          640'({h.wre & v, h.vwre & v, h.mwa & v, h.mwb & v, h.wb_sel, h.vwb_sel,
                h.rs1, h.rs2, h.rd, h.alu, h.srcA, h.srcB, h.valu, h.vsrcB}));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic v, input pay_t p);
    in_valid = v;
    cur_in   = p;
  endtask

  initial begin
    pay_t p;
    logic [255:0] pat;

    // reset state
    cycle();
    cycle();
    chk("rst_out_valid", 640'(n_out_valid), 640'(0));
    chk("rst_in_ready", 640'(n_in_ready), 640'(1));
    chk("rst_occ", 640'(n_occ), 640'(0));
    chk("rst_n_payload", n_pay_act(), 640'(0));
    chk("rst_w_payload", w_pay_act(), 640'(0));
    reset = 1'b0;

    // streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p = rand_pay();
      p.alu = 32'h11 * (i + 1);
      set_in(1'b1, p);
      cycle();
      chk("stream_alu", 640'(n_alu), 640'(16'h11 * (i + 1)));
      chk("stream_ctrl", 640'({n_out_valid, n_in_ready, n_occ}), 640'({1'b1, 1'b1, 2'd1}));
    end
    set_in(1'b0, '0);
    cycle();
    chk("stream_drain", 640'(n_out_valid), 640'(0));

    // stall and skid
    out_ready = 1'b0;
    p = rand_pay(); p.rd = 5'd3;
    set_in(1'b1, p);
    cycle();
    p = rand_pay(); p.rd = 5'd7;
    set_in(1'b1, p);
    cycle();
    chk("skid_occ", 640'(n_occ), 640'(2));
    chk("skid_in_ready", 640'(n_in_ready), 640'(0));
    chk("skid_rd_a", 640'(n_rd), 640'(3));
    set_in(1'b0, '0);
    out_ready = 1'b1;
    cycle();
    chk("skid_rd_b", 640'(n_rd), 640'(7));
    chk("skid_ready_back", 640'({n_in_ready, n_occ}), 640'({1'b1, 2'd1}));
    cycle();
    chk("skid_empty", 640'(n_out_valid), 640'(0));

    // bubble gating
    p = rand_pay(); p.wre = 1'b1; p.mwa = 1'b1; p.alu = 32'h0000_BEEF;
    set_in(1'b1, p);
    cycle();
    chk("bub_live", 640'({n_out_valid, n_wre, n_mwa}), 640'(3'b111));
    set_in(1'b0, '0);
    cycle();
    chk("bub_gated", 640'({n_out_valid, n_wre, n_mwa}), 640'(3'b000));
    chk("bub_alu_hold", 640'(n_alu), 640'(16'hBEEF));

    // flush with one entry: the accept in the same cycle is discarded
    out_ready = 1'b0;
    p = rand_pay(); p.vsrcB = '0;
    set_in(1'b1, p);
    cycle();
    p = rand_pay(); p.vsrcB = '1;
    set_in(1'b1, p);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    set_in(1'b0, '0);
    chk("flush1_ctrl", 640'({n_out_valid, n_in_ready, n_occ}), 640'({1'b0, 1'b1, 2'd0}));
    out_ready = 1'b1;
    cycle();
    chk("flush1_no_ghost", 640'({w_out_valid, w_vsrcB}), 640'(0));

    // flush with a full buffer
    out_ready = 1'b0;
    p = rand_pay(); p.vsrcB = '0;
    set_in(1'b1, p);
    cycle();
    p = rand_pay(); p.vsrcB = 256'h5;
    set_in(1'b1, p);
    cycle();
    chk("flush2_full", 640'(n_occ), 640'(2));
    p = rand_pay(); p.vsrcB = '1;
    set_in(1'b1, p);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    set_in(1'b0, '0);
    chk("flush2_ctrl", 640'({w_out_valid, w_in_ready, w_occ}), 640'({1'b0, 1'b1, 2'd0}));
    out_ready = 1'b1;
    cycle();
    cycle();
    chk("flush2_no_ghost", 640'({w_out_valid, w_vsrcB}), 640'(0));

    // reset while stalled, with flush and input active
    out_ready = 1'b0;
    set_in(1'b1, rand_pay());
    cycle();
    set_in(1'b1, rand_pay());
    cycle();
    reset = 1'b1;
    flush = 1'b1;
    set_in(1'b1, rand_pay());
    cycle();
    chk("rst2_ctrl", 640'({n_out_valid, n_in_ready, n_occ}), 640'({1'b0, 1'b1, 2'd0}));
    chk("rst2_n_payload", n_pay_act(), 640'(0));
    chk("rst2_w_payload", w_pay_act(), 640'(0));
    reset = 1'b0;
    flush = 1'b0;

    // full-width payload pass-through
    out_ready = 1'b1;
    pat = {64'hFEDC_BA98_7654_3210, 64'h0F1E_2D3C_4B5A_6978,
           64'h8000_0000_0000_0001, 64'hA5A5_5A5A_C3C3_3C3C};
    p = rand_pay(); p.valu = pat; p.alu = 32'h8765_4321;
    set_in(1'b1, p);
    cycle();
    chk("wide_valu", 640'(w_valu), 640'(pat));
    chk("narrow_valu", 640'(n_valu), 640'(pat[127:0]));
    chk("wide_alu", 640'(w_alu), 640'(32'h8765_4321));
    chk("narrow_alu", 640'(n_alu), 640'(16'h4321));

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      cur_in    = rand_pay();
      cycle();
    end
    reset = 1'b0;
    flush = 1'b0;
    set_in(1'b0, '0);
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
